mac_pe_dbuf: RTL and testbench

- Parametrised next-generation systolic-array processing element.
- Signed multiply-accumulate with independent data and accumulator widths, and optional saturation.
- Double-buffered stationary weights: the next weight loads while the current one computes.
- Valid-qualified data flow in both directions.
- Output-stationary (OS) result drain through the vertical chain.
- Tiles into an R×C mesh: horizontal links carry operands; vertical links carry weights, partial sums or drained results.

---
 rtl/pe_pkg.sv | 42 ++++
 rtl/pe_sat_mac.sv | 29 ++
 rtl/mac_pe_dbuf.sv | 134 +++++++++++++
 tb/tb_mac_pe_dbuf.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and the saturating adder for the mac_pe_dbuf processing element.
package pe_pkg;

  typedef enum logic {
    ModeWs = 1'b0,
    ModeOs = 1'b1
  } pe_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDrainOwn,
    StDrainFwd
  } os_state_e;

  // Widest accumulator the adder supports; callers sign-extend into this width.
  localparam int unsigned MaxAccW = 64;

  typedef logic signed [MaxAccW-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t sum;
  } sat_res_t;

  // Exact sum of two sign-extended acc_w values, checked against the acc_w signed range.
  function automatic sat_res_t sat_add(input wide_t x, input wide_t y,
                                       input int unsigned acc_w, input logic sat_en);
    wide_t    s;
    wide_t    hi;
    wide_t    lo;
    sat_res_t r;
    s     = x + y;
    hi    = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    lo    = -hi - wide_t'(1);
    r.ovf = (s > hi) || (s < lo);
    r.sum = s;
    if (r.ovf && sat_en) r.sum = (s > hi) ? hi : lo;
    return r;
  endfunction

endpackage

// File: rtl/pe_sat_mac.sv
// Combinational signed multiply-add with saturate or wrap, shared by WS and OS paths.
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  addend,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  logic signed [2*DATA_W-1:0] prod;
  sat_res_t                   res;
  logic                       unused_hi;

  always_comb begin
    prod   = $signed(a) * $signed(b);
    res    = sat_add(wide_t'(prod), wide_t'($signed(addend)), ACC_W, SAT_EN);
    result = res.sum[ACC_W-1:0];
    ovf    = res.ovf;
  end

  assign unused_hi = ^res.sum[MaxAccW-1:ACC_W];

endmodule

// File: rtl/mac_pe_dbuf.sv
// Systolic PE: WS mode with double-buffered weights, OS mode with accumulate and drain chain.
module mac_pe_dbuf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              load_w,
  input  logic              swap_w,
  input  logic              clr_acc,
  input  logic              drain,
  input  logic [DATA_W-1:0] left_in,
  input  logic              left_vld,
  input  logic [ACC_W-1:0]  top_in,
  input  logic              top_vld,
  output logic [DATA_W-1:0] right_out,
  output logic              right_vld,
  output logic [ACC_W-1:0]  bottom_out,
  output logic              bottom_vld,
  output logic              sat_flag
);

  logic [DATA_W-1:0] a_q, w_shadow_q, w_act_q;
  logic [ACC_W-1:0]  b_q, acc_q, bottom_hold_q;
  logic              a_vld_q, b_vld_q, load_q, clr_pend_q, sat_q;
  os_state_e         state_q;

  logic              is_os, pair_vld, os_acc_en, ws_out_en, mac_ovf;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_add, mac_res;

  assign is_os     = (mode == ModeOs);
  assign pair_vld  = a_vld_q & b_vld_q;
  assign os_acc_en = is_os & pair_vld & ((state_q == StIdle) | (state_q == StAcc));
  assign ws_out_en = ~is_os & pair_vld;
  // A clear coinciding with a valid pair makes that pair overwrite acc.
  assign mac_b     = is_os ? b_q[DATA_W-1:0] : w_act_q;
  assign mac_add   = is_os ? ((clr_pend_q | clr_acc) ? '0 : acc_q) : b_q;

  pe_sat_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .SAT_EN(SAT_EN)
  ) u_sat_mac (
    .a     (a_q),
    .b     (mac_b),
    .addend(mac_add),
    .result(mac_res),
    .ovf   (mac_ovf)
  );

  assign right_out = a_q;
  assign right_vld = a_vld_q;
  assign sat_flag  = sat_q;

  always_comb begin
    bottom_out = bottom_hold_q;
    bottom_vld = 1'b0;
    if (!is_os) begin
      if (pair_vld) begin
        bottom_out = mac_res;
        bottom_vld = 1'b1;
      end else if (load_q) begin
        bottom_out = b_q;
      end
    end else if (state_q == StDrainOwn) begin
      bottom_out = acc_q;
      bottom_vld = 1'b1;
    end else begin
      bottom_out = b_q;
      bottom_vld = b_vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      a_vld_q       <= 1'b0;
      b_q           <= '0;
      b_vld_q       <= 1'b0;
      load_q        <= 1'b0;
      bottom_hold_q <= '0;
      w_shadow_q    <= '0;
      w_act_q       <= '0;
      acc_q         <= '0;
      clr_pend_q    <= 1'b0;
      sat_q         <= 1'b0;
      state_q       <= StIdle;
    end else begin
      a_q           <= left_in;
      a_vld_q       <= left_vld;
      b_q           <= top_in;
      b_vld_q       <= top_vld;
      load_q        <= load_w;
      bottom_hold_q <= bottom_out;
      if (load_w) w_shadow_q <= top_in[DATA_W-1:0];
      if (swap_w) w_act_q <= w_shadow_q;
      if (clr_acc) begin
        sat_q      <= 1'b0;
        clr_pend_q <= 1'b1;
      end
      if ((ws_out_en | os_acc_en) & mac_ovf) sat_q <= 1'b1;
      if (os_acc_en) begin
        acc_q      <= mac_res;
        clr_pend_q <= 1'b0;
      end
      if (!is_os) begin
        if (state_q != StIdle) begin
          state_q <= StIdle;
          acc_q   <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle:     if (pair_vld) state_q <= StAcc;
          StAcc:      if (drain) state_q <= StDrainOwn;
          StDrainOwn: begin
            acc_q   <= '0;
            state_q <= drain ? StDrainFwd : StIdle;
          end
          StDrainFwd: begin
            acc_q <= '0;
            if (!drain) state_q <= StIdle;
          end
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_pe_dbuf.sv
// Directed bench for mac_pe_dbuf: one 40-bit saturating PE plus 32-bit saturate and wrap PEs.
module tb_mac_pe_dbuf;

  logic        clk;
  logic        rst_n;
  logic        mode, load_w, swap_w, clr_acc, drain, left_vld, top_vld;
  logic [15:0] left_in;
  logic [39:0] top_in;

  logic [15:0] d_right_out, s_right_out, w_right_out;
  logic        d_right_vld, s_right_vld, w_right_vld;
  logic [39:0] d_bottom_out;
  logic [31:0] s_bottom_out, w_bottom_out;
  logic        d_bottom_vld, s_bottom_vld, w_bottom_vld;
  logic        d_sat, s_sat, w_sat;

  int n_chk;
  int n_fail;

  mac_pe_dbuf #(.DATA_W(16), .ACC_W(40), .SAT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .load_w(load_w), .swap_w(swap_w),
    .clr_acc(clr_acc), .drain(drain), .left_in(left_in), .left_vld(left_vld),
    .top_in(top_in), .top_vld(top_vld), .right_out(d_right_out), .right_vld(d_right_vld),
    .bottom_out(d_bottom_out), .bottom_vld(d_bottom_vld), .sat_flag(d_sat)
  );

  mac_pe_dbuf #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .mode(mode), .load_w(load_w), .swap_w(swap_w),
    .clr_acc(clr_acc), .drain(drain), .left_in(left_in), .left_vld(left_vld),
    .top_in(top_in[31:0]), .top_vld(top_vld), .right_out(s_right_out),
    .right_vld(s_right_vld), .bottom_out(s_bottom_out), .bottom_vld(s_bottom_vld),
    .sat_flag(s_sat)
  );

  mac_pe_dbuf #(.DATA_W(16), .ACC_W(32), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .mode(mode), .load_w(load_w), .swap_w(swap_w),
    .clr_acc(clr_acc), .drain(drain), .left_in(left_in), .left_vld(left_vld),
    .top_in(top_in[31:0]), .top_vld(top_vld), .right_out(w_right_out),
    .right_vld(w_right_vld), .bottom_out(w_bottom_out), .bottom_vld(w_bottom_vld),
    .sat_flag(w_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    load_w = 0; swap_w = 0; clr_acc = 0; drain = 0;
    left_in = '0; left_vld = 0; top_in = '0; top_vld = 0;
  endtask

  task automatic pair(input logic [15:0] l, input logic [39:0] t);
    left_in = l; left_vld = 1; top_in = t; top_vld = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; mode = 0; idle_in();
    repeat (2) @(negedge clk);
    n_chk++; if (d_right_out !== 16'd0) begin n_fail++;
      $display("FAIL reset_right_out: got %h, expected 0", d_right_out); end
    n_chk++; if (d_right_vld !== 1'b0) begin n_fail++;
      $display("FAIL reset_right_vld: got %b, expected 0", d_right_vld); end
    n_chk++; if (d_bottom_out !== 40'd0) begin n_fail++;
      $display("FAIL reset_bottom_out: got %h, expected 0", d_bottom_out); end
    n_chk++; if (d_bottom_vld !== 1'b0) begin n_fail++;
      $display("FAIL reset_bottom_vld: got %b, expected 0", d_bottom_vld); end
    n_chk++; if (d_sat !== 1'b0 || s_sat !== 1'b0 || w_sat !== 1'b0) begin n_fail++;
      $display("FAIL reset_sat_flag: got %b%b%b, expected 000", d_sat, s_sat, w_sat); end
    rst_n = 1;
  endtask

  task automatic test_ws_basic();
    mode = 0; idle_in();
    load_w = 1; top_in = 40'd3; cyc();
    load_w = 0; swap_w = 1; top_in = '0; cyc();
    swap_w = 0; pair(-16'sd5, 40'd100); cyc();
    n_chk++; if (d_bottom_out !== 40'd85 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL ws_psum: got %0d vld %b, expected 85 vld 1", d_bottom_out, d_bottom_vld); end
    n_chk++; if (d_right_out !== 16'hFFFB || d_right_vld !== 1'b1) begin n_fail++;
      $display("FAIL ws_right_out: got %h vld %b, expected fffb vld 1", d_right_out, d_right_vld); end
    idle_in(); cyc();
    n_chk++; if (d_bottom_vld !== 1'b0) begin n_fail++;
      $display("FAIL ws_vld_drop: got %b, expected 0", d_bottom_vld); end
    n_chk++; if (d_bottom_out !== 40'd85) begin n_fail++;
      $display("FAIL ws_hold: got %0d, expected 85", d_bottom_out); end
  endtask

  task automatic test_ws_dbuf();
    mode = 0; idle_in();
    pair(16'd2, 40'd0); cyc();
    n_chk++; if (d_bottom_out !== 40'd6) begin n_fail++;
      $display("FAIL dbuf_pre: got %0d, expected 6", d_bottom_out); end
    // Same-cycle load+swap: active takes the old shadow (3), shadow takes 7.
    load_w = 1; swap_w = 1; pair(16'd2, 40'd7); cyc();
    n_chk++; if (d_bottom_out !== 40'd13 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL dbuf_same_cycle: got %0d vld %b, expected 13 vld 1", d_bottom_out,
               d_bottom_vld); end
    load_w = 0; swap_w = 1; pair(16'd2, 40'd0); cyc();
    n_chk++; if (d_bottom_out !== 40'd14) begin n_fail++;
      $display("FAIL dbuf_post_swap: got %0d, expected 14", d_bottom_out); end
    idle_in(); cyc();
  endtask

  task automatic test_os_acc();
    idle_in(); mode = 1; clr_acc = 1; cyc();
    clr_acc = 0; pair(16'd2, 40'd3); cyc();
    n_chk++; if (d_bottom_out !== 40'd3 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL os_passthrough: got %0d vld %b, expected 3 vld 1", d_bottom_out,
               d_bottom_vld); end
    pair(16'd4, 40'd5); cyc();
    pair(-16'sd1, 40'd6); cyc();
    pair(16'd10, 40'd10); cyc();
    idle_in(); cyc();
    drain = 1; cyc();
    n_chk++; if (d_bottom_out !== 40'd120 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL os_drain_own: got %0d vld %b, expected 120 vld 1", d_bottom_out,
               d_bottom_vld); end
    drain = 0; cyc();
    n_chk++; if (d_bottom_vld !== 1'b0) begin n_fail++;
      $display("FAIL os_drain_end: got vld %b, expected 0", d_bottom_vld); end
  endtask

  task automatic test_os_drain_chain();
    idle_in(); mode = 1;
    pair(16'd7, 40'd8); cyc();
    idle_in(); cyc();
    drain = 1; top_in = 40'd55; top_vld = 1; cyc();
    n_chk++; if (d_bottom_out !== 40'd56 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL chain_own: got %0d vld %b, expected 56 vld 1", d_bottom_out,
               d_bottom_vld); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_chk++; if (d_bottom_out !== 40'd55 || d_bottom_vld !== 1'b1) begin n_fail++;
        $display("FAIL chain_fwd%0d: got %0d vld %b, expected 55 vld 1", i, d_bottom_out,
                 d_bottom_vld); end
    end
    idle_in(); cyc();
    n_chk++; if (d_bottom_vld !== 1'b0) begin n_fail++;
      $display("FAIL chain_end: got vld %b, expected 0", d_bottom_vld); end
  endtask

  task automatic test_mode_change();
    idle_in(); mode = 1;
    pair(16'd3, 40'd3); cyc();
    idle_in(); cyc();
    mode = 0; cyc();
    mode = 1; pair(16'd1, 40'd1); cyc();
    idle_in(); cyc();
    drain = 1; cyc();
    n_chk++; if (d_bottom_out !== 40'd1 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL mode_change_acc_clear: got %0d vld %b, expected 1 vld 1", d_bottom_out,
               d_bottom_vld); end
    drain = 0; cyc();
    mode = 0; pair(16'd1, 40'd0); cyc();
    n_chk++; if (d_bottom_out !== 40'd7) begin n_fail++;
      $display("FAIL weight_retained: got %0d, expected 7", d_bottom_out); end
    idle_in(); cyc();
  endtask

  task automatic test_saturation();
    mode = 0; idle_in();
    load_w = 1; top_in = 40'd4; cyc();
    load_w = 0; swap_w = 1; top_in = '0; cyc();
    swap_w = 0; pair(16'd3, 40'h00_7FFF_FFF6); cyc();
    n_chk++; if (s_bottom_out !== 32'h7FFF_FFFF) begin n_fail++;
      $display("FAIL sat_pos: got %h, expected 7fffffff", s_bottom_out); end
    n_chk++; if (w_bottom_out !== 32'h8000_0002) begin n_fail++;
      $display("FAIL wrap_pos: got %h, expected 80000002", w_bottom_out); end
    n_chk++; if (s_sat !== 1'b0) begin n_fail++;
      $display("FAIL sat_flag_early: got %b, expected 0", s_sat); end
    pair(-16'sd3, 40'hFF_8000_0005); cyc();
    n_chk++; if (s_sat !== 1'b1 || w_sat !== 1'b1 || d_sat !== 1'b0) begin n_fail++;
      $display("FAIL sat_flag_set: got %b%b%b, expected 110 (sat wrap wide)", s_sat, w_sat,
               d_sat); end
    n_chk++; if (s_bottom_out !== 32'h8000_0000) begin n_fail++;
      $display("FAIL sat_neg: got %h, expected 80000000", s_bottom_out); end
    n_chk++; if (w_bottom_out !== 32'h7FFF_FFF9) begin n_fail++;
      $display("FAIL wrap_neg: got %h, expected 7ffffff9", w_bottom_out); end
    n_chk++; if (d_bottom_out !== 40'hFF_7FFF_FFF9) begin n_fail++;
      $display("FAIL wide_no_sat: got %h, expected ff7ffffff9", d_bottom_out); end
    idle_in(); cyc();
    clr_acc = 1; cyc();
    n_chk++; if (s_sat !== 1'b0 || w_sat !== 1'b0) begin n_fail++;
      $display("FAIL sat_flag_clear: got %b%b, expected 00", s_sat, w_sat); end
    idle_in(); cyc();
  endtask

  task automatic test_async_reset();
    idle_in(); mode = 1;
    pair(16'd5, 40'd5); cyc();
    idle_in(); cyc();
    drain = 1; top_in = 40'd55; top_vld = 1; left_in = 16'd9; left_vld = 1; cyc();
    cyc();
    n_chk++; if (d_bottom_out !== 40'd55 || d_right_out !== 16'd9) begin n_fail++;
      $display("FAIL pre_reset_fwd: got %0d/%0d, expected 55/9", d_bottom_out, d_right_out); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (d_bottom_out !== 40'd0 || d_bottom_vld !== 1'b0) begin n_fail++;
      $display("FAIL async_bottom: got %0d vld %b, expected 0 vld 0", d_bottom_out,
               d_bottom_vld); end
    n_chk++; if (d_right_out !== 16'd0 || d_right_vld !== 1'b0 || d_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL async_right: got %h vld %b sat %b, expected 0 0 0", d_right_out,
               d_right_vld, d_sat); end
    @(negedge clk);
    idle_in(); rst_n = 1;
    pair(16'd2, 40'd2); cyc();
    idle_in(); cyc();
    drain = 1; cyc();
    n_chk++; if (d_bottom_out !== 40'd4 || d_bottom_vld !== 1'b1) begin n_fail++;
      $display("FAIL post_reset_acc: got %0d vld %b, expected 4 vld 1", d_bottom_out,
               d_bottom_vld); end
    idle_in(); cyc();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_ws_basic();
    test_ws_dbuf();
    test_os_acc();
    test_os_drain_chain();
    test_mode_change();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
